// File: rtl/ext_bus_regbank_if.sv
// External parallel bus bundle between the board IOBUF split and the register bank.
// Latency: none. This file only carries wires.
// Backpressure: none. The bus is strobe-based and the master holds its signals stable while cs_i is high.
interface ext_bus_regbank_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3
);
   logic                  cs_i;
   logic                  read_n_i;
   logic                  write_n_i;
   logic [ADDR_WIDTH-1:0] addr_i;
   logic [DATA_WIDTH-1:0] data_i;
   logic [DATA_WIDTH-1:0] data_o;
   logic                  data_oe_o;

   // External bus master, such as the CPU side or a testbench.
   modport master (
      output cs_i, read_n_i, write_n_i, addr_i, data_i,
      input  data_o, data_oe_o
   );

   // Register bank side.
   modport slave (
      input  cs_i, read_n_i, write_n_i, addr_i, data_i,
      output data_o, data_oe_o
   );
endinterface

// File: rtl/ext_bus_regbank.sv
// Parametrised register bank behind the asynchronous external parallel bus (optional IRQ: EXT_REGBANK_IRQ_EN).
// Latency: one access SYNC_STAGES-1 clk_i edges after cs_i is first sampled high; irq_o is one cycle behind pending/enable.
// Backpressure: none. There is exactly one access per cs_i rising edge, and a held cs_i never repeats the access.
module ext_bus_regbank #(
   parameter int                              DATA_WIDTH   = 16,
   parameter int                              ADDR_WIDTH   = 3,
   parameter int                              SYNC_STAGES  = 3,
   parameter logic [DATA_WIDTH-1:0]           ID_VALUE     = 16'h50FE,
   parameter logic [(2**ADDR_WIDTH)-1:0]      RO_MASK      = 8'b1100_0001,
   parameter int                              CTRL_IDX     = 5,
   parameter logic [DATA_WIDTH-1:0]           PULSE_MASK   = 16'h0028,
   parameter int                              IRQ_PEND_IDX = 3,
   parameter int                              IRQ_EN_IDX   = 4
) (
   input  logic                                        clk_i,
   input  logic                                        reset_i,
   ext_bus_regbank_if.slave                            bus,
   input  logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]       ro_data_i,
   output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]       rw_data_o,
   input  logic [DATA_WIDTH-1:0]                       irq_src_i,
   output logic                                        irq_o
);
   localparam int                    NUM_REGS = 2**ADDR_WIDTH;
   // Register 0 is the ID register, so it is always read-only.
   localparam logic [NUM_REGS-1:0]   L_RO     = RO_MASK | NUM_REGS'(1);
   localparam logic [ADDR_WIDTH-1:0] L_CTRL   = ADDR_WIDTH'(CTRL_IDX);

   if (SYNC_STAGES < 3) begin : g_bad_sync
      $error("ext_bus_regbank: SYNC_STAGES must be >= 3");
   end
   if (DATA_WIDTH < 8) begin : g_bad_width
      $error("ext_bus_regbank: DATA_WIDTH must be >= 8");
   end

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_access;
   logic                   w_rd;
   logic                   w_wr;
   logic [DATA_WIDTH-1:0]  r_regs [NUM_REGS];
   logic [DATA_WIDTH-1:0]  w_rd_val;
   logic [DATA_WIDTH-1:0]  r_data_o;

   // Move cs_i into the clk_i domain. Only the settled tail stages are used for edge detection.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.cs_i};
      end
   end

   // This is a single-cycle strobe on the synchronised rising edge of cs_i. The bus fields are
   // stable by then, so they are sampled directly without their own synchronisers.
   assign w_access = r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];
   assign w_rd     = w_access & ~bus.read_n_i;
   assign w_wr     = w_access & ~bus.write_n_i & ~L_RO[bus.addr_i];

`ifdef EXT_REGBANK_IRQ_EN
   localparam logic [ADDR_WIDTH-1:0] L_PEND = ADDR_WIDTH'(IRQ_PEND_IDX);

   logic [DATA_WIDTH-1:0] r_irq_s1;
   logic [DATA_WIDTH-1:0] r_irq_s2;
   logic [DATA_WIDTH-1:0] r_irq_s3;
   logic [DATA_WIDTH-1:0] w_irq_rise;
   logic                  w_pend_wr;
   logic                  r_irq;

   // Double-flop the interrupt sources and keep one more stage for rising-edge detection.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_irq_s1 <= '0;
         r_irq_s2 <= '0;
         r_irq_s3 <= '0;
      end else begin
         r_irq_s1 <= irq_src_i;
         r_irq_s2 <= r_irq_s1;
         r_irq_s3 <= r_irq_s2;
      end
   end

   assign w_irq_rise = r_irq_s2 & ~r_irq_s3;
   // The pending register is write-1-to-clear whatever RO_MASK says about it.
   assign w_pend_wr  = w_access & ~bus.write_n_i & (bus.addr_i == L_PEND);

   // Interrupt request, registered from the pending bits that are also enabled.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |(r_regs[IRQ_PEND_IDX] & r_regs[IRQ_EN_IDX]);
      end
   end

   assign irq_o = r_irq;
`else
   logic w_unused_irq;
   assign w_unused_irq = (^irq_src_i) ^ (IRQ_PEND_IDX == IRQ_EN_IDX);
   assign irq_o        = 1'b0;
`endif

   // Register storage. Pulse bits clear on every cycle unless a write lands on that same cycle.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         r_regs[CTRL_IDX] <= r_regs[CTRL_IDX] & ~PULSE_MASK;
         if (w_wr) begin
            r_regs[bus.addr_i] <= bus.data_i;
         end
`ifdef EXT_REGBANK_IRQ_EN
         // A new edge wins over a clear of the same bit.
         r_regs[IRQ_PEND_IDX] <= (r_regs[IRQ_PEND_IDX] & ~(w_pend_wr ? bus.data_i : '0))
                                 | w_irq_rise;
`endif
      end
   end

   // Read mux: the ID constant, external read-only sources, or stored contents with pulse bits hidden.
   always_comb begin
      w_rd_val = r_regs[bus.addr_i];
      if (bus.addr_i == '0) begin
         w_rd_val = ID_VALUE;
      end else if (L_RO[bus.addr_i]) begin
         w_rd_val = ro_data_i[bus.addr_i*DATA_WIDTH +: DATA_WIDTH];
      end
`ifdef EXT_REGBANK_IRQ_EN
      if (bus.addr_i == L_PEND) begin
         w_rd_val = r_regs[IRQ_PEND_IDX];
      end
`endif
      if (bus.addr_i == L_CTRL) begin
         w_rd_val = w_rd_val & ~PULSE_MASK;
      end
   end

   // Read data holds between read accesses. The old value is captured before any write on the same edge.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_data_o <= '0;
      end else if (w_rd) begin
         r_data_o <= w_rd_val;
      end
   end

   // Flatten the read-write contents for the SoC. Read-only slots read as zero.
   always_comb begin
      rw_data_o = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         rw_data_o[i*DATA_WIDTH +: DATA_WIDTH] = L_RO[i] ? '0 : r_regs[i];
      end
   end

   assign bus.data_o    = r_data_o;
   assign bus.data_oe_o = bus.cs_i & ~bus.read_n_i;
endmodule

// File: tb/tb_ext_bus_regbank.sv
module tb_ext_bus_regbank;
   localparam int          S     = 3;
   localparam logic [7:0]  RO    = 8'b1100_0001;
   localparam logic [15:0] PULSE = 16'h0028;
   localparam logic [15:0] ID    = 16'h50FE;

   logic         clk;
   logic         reset_n;
   logic [127:0] ro_data;
   logic [127:0] rw_data;
   logic [15:0]  irq_src;
   logic         irq;

   int tests;
   int failed;

   // Reference model: the logical register contents and the last value read.
   logic [15:0] m_regs [8];
   logic [15:0] m_data;

   ext_bus_regbank_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus_if ();

   ext_bus_regbank dut (
      .clk_i     (clk),
      .reset_i   (reset_n),
      .bus       (bus_if),
      .ro_data_i (ro_data),
      .rw_data_o (rw_data),
      .irq_src_i (irq_src),
      .irq_o     (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   typedef struct {
      bit          rd;
      bit          wr;
      logic [2:0]  a;
      logic [15:0] d;
      logic [15:0] exp_do;
      logic [15:0] exp_slice;
   } vec_t;

   vec_t tbl [13];

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] m_read(input logic [2:0] a);
      if (a == 3'd0) return ID;
      if (RO[a]) return ro_data[a*16 +: 16];
      if (a == 3'd5) return m_regs[a] & ~PULSE;
      return m_regs[a];
   endfunction

   function automatic logic [127:0] m_rw();
      logic [127:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) begin
         if (!RO[i]) v[i*16 +: 16] = (i == 5) ? (m_regs[i] & ~PULSE) : m_regs[i];
      end
      return v;
   endfunction

   function automatic logic m_irq();
`ifdef EXT_REGBANK_IRQ_EN
      return |(m_regs[3] & m_regs[4]);
`else
      return 1'b0;
`endif
   endfunction

   // One complete bus cycle. It is entered and left at #1 after a rising edge, and the model is updated.
   task automatic access(input bit rd, input bit wr, input logic [2:0] a, input logic [15:0] d);
      bus_if.addr_i    = a;
      bus_if.data_i    = d;
      bus_if.read_n_i  = ~rd;
      bus_if.write_n_i = ~wr;
      bus_if.cs_i      = 1'b1;
      repeat (S) @(posedge clk);
      #1;
      bus_if.cs_i      = 1'b0;
      bus_if.read_n_i  = 1'b1;
      bus_if.write_n_i = 1'b1;
      repeat (S + 1) @(posedge clk);
      #1;
      if (rd) m_data = m_read(a);
      if (wr) begin
`ifdef EXT_REGBANK_IRQ_EN
         if (a == 3'd3) m_regs[3] = m_regs[3] & ~d;
         else if (!RO[a]) m_regs[a] = d;
`else
         if (!RO[a]) m_regs[a] = d;
`endif
      end
   endtask

   initial begin
      bit          rd;
      bit          wr;
      logic [2:0]  a;
      logic [15:0] d;
      logic [15:0] exp_do;
      bit          seen;

      tests  = 0;
      failed = 0;
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_data = '0;
      for (int i = 0; i < 8; i++) ro_data[i*16 +: 16] = 16'hC000 + 16'(i);
      ro_data[6*16 +: 16] = 16'h1234;
      ro_data[7*16 +: 16] = 16'h7777;
      irq_src          = '0;
      bus_if.cs_i      = 1'b0;
      bus_if.read_n_i  = 1'b1;
      bus_if.write_n_i = 1'b1;
      bus_if.addr_i    = '0;
      bus_if.data_i    = '0;
      reset_n          = 1'b1;
      #1 reset_n = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("reset data_o", 128'(bus_if.data_o), 128'h0);
      check("reset rw_data_o", rw_data, 128'h0);
      check("reset irq_o", 128'(irq), 128'h0);
      check("reset data_oe_o", 128'(bus_if.data_oe_o), 128'h0);

      // First read after release: no update before edge n+S-1.
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      bus_if.addr_i   = 3'd0;
      bus_if.read_n_i = 1'b0;
      bus_if.cs_i     = 1'b1;
      #1 check("data_oe_o during read", 128'(bus_if.data_oe_o), 128'h1);
      @(posedge clk); #1 check("id edge n", 128'(bus_if.data_o), 128'h0);
      @(posedge clk); #1 check("id edge n+1", 128'(bus_if.data_o), 128'h0);
      @(posedge clk); #1 check("id edge n+2", 128'(bus_if.data_o), 128'(ID));
      bus_if.cs_i     = 1'b0;
      bus_if.read_n_i = 1'b1;
      repeat (S + 1) @(posedge clk);
      #1;
      m_data = ID;
      check("data_oe_o idle", 128'(bus_if.data_oe_o), 128'h0);

      // Table of directed vectors.
      tbl[0]  = '{1'b0, 1'b1, 3'd1, 16'hA5A5, 16'h50FE, 16'hA5A5};
      tbl[1]  = '{1'b1, 1'b0, 3'd1, 16'h0000, 16'hA5A5, 16'hA5A5};
      tbl[2]  = '{1'b0, 1'b1, 3'd6, 16'hBEEF, 16'hA5A5, 16'h0000};
      tbl[3]  = '{1'b1, 1'b0, 3'd6, 16'h0000, 16'h1234, 16'h0000};
      tbl[4]  = '{1'b0, 1'b1, 3'd0, 16'hFFFF, 16'h1234, 16'h0000};
      tbl[5]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 16'h50FE, 16'h0000};
      tbl[6]  = '{1'b1, 1'b1, 3'd1, 16'h5A5A, 16'hA5A5, 16'h5A5A};
      tbl[7]  = '{1'b1, 1'b0, 3'd1, 16'h0000, 16'h5A5A, 16'h5A5A};
      tbl[8]  = '{1'b1, 1'b0, 3'd7, 16'h0000, 16'h7777, 16'h0000};
      tbl[9]  = '{1'b0, 1'b1, 3'd4, 16'h00FF, 16'h7777, 16'h00FF};
      tbl[10] = '{1'b1, 1'b0, 3'd4, 16'h0000, 16'h00FF, 16'h00FF};
      tbl[11] = '{1'b0, 1'b1, 3'd5, 16'hFFFF, 16'h00FF, 16'hFFD7};
      tbl[12] = '{1'b1, 1'b0, 3'd5, 16'h0000, 16'hFFD7, 16'hFFD7};
      for (int i = 0; i < 13; i++) begin
         access(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
         check($sformatf("vec%0d data_o", i), 128'(bus_if.data_o), 128'(tbl[i].exp_do));
         check($sformatf("vec%0d rw slice", i), 128'(rw_data[tbl[i].a*16 +: 16]),
               128'(tbl[i].exp_slice));
      end

      // Pulse bits: high for exactly one cycle and never read back.
      bus_if.addr_i    = 3'd5;
      bus_if.data_i    = 16'h0028;
      bus_if.write_n_i = 1'b0;
      bus_if.cs_i      = 1'b1;
      repeat (S) @(posedge clk);
      #1 check("pulse high", 128'(rw_data[5*16 +: 16]), 128'h0028);
      @(posedge clk);
      #1 check("pulse cleared", 128'(rw_data[5*16 +: 16]), 128'h0000);
      bus_if.cs_i      = 1'b0;
      bus_if.write_n_i = 1'b1;
      repeat (S + 1) @(posedge clk);
      #1;
      m_regs[5] = 16'h0000;
      access(1'b1, 1'b0, 3'd5, 16'h0);
      check("pulse readback", 128'(bus_if.data_o), 128'h0000);

      // Holding cs_i high performs one write only. Data is changed afterwards to expose any repeat.
      bus_if.addr_i    = 3'd2;
      bus_if.data_i    = 16'h0001;
      bus_if.write_n_i = 1'b0;
      bus_if.cs_i      = 1'b1;
      repeat (S) @(posedge clk);
      #1 check("hold first write", 128'(rw_data[2*16 +: 16]), 128'h0001);
      bus_if.data_i = 16'hFFFF;
      repeat (20 - S) @(posedge clk);
      #1 check("hold no repeat", 128'(rw_data[2*16 +: 16]), 128'h0001);
      bus_if.cs_i      = 1'b0;
      bus_if.write_n_i = 1'b1;
      repeat (S + 1) @(posedge clk);
      #1;
      m_regs[2] = 16'h0001;

      // Randomised accesses against the model.
      for (int i = 0; i < 40; i++) begin
         ro_data = {$urandom, $urandom, $urandom, $urandom};
         case ($urandom_range(0, 2))
            0:       begin rd = 1'b1; wr = 1'b0; end
            1:       begin rd = 1'b0; wr = 1'b1; end
            default: begin rd = 1'b1; wr = 1'b1; end
         endcase
         a      = 3'($urandom_range(0, 7));
         d      = 16'($urandom);
         exp_do = rd ? m_read(a) : m_data;
         access(rd, wr, a, d);
         check($sformatf("rand%0d data_o a=%0d", i, a), 128'(bus_if.data_o), 128'(exp_do));
         check($sformatf("rand%0d rw_data_o", i), rw_data, m_rw());
         check($sformatf("rand%0d irq_o", i), 128'(irq), 128'(m_irq()));
      end

`ifdef EXT_REGBANK_IRQ_EN
      // Interrupt path: edge to request, coincident set wins over clear, then clear.
      access(1'b0, 1'b1, 3'd4, 16'h0004);
      access(1'b0, 1'b1, 3'd3, 16'hFFFF);
      irq_src[2] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (irq) seen = 1'b1;
      end
      check("irq within 4", 128'(seen), 128'h1);
      check("pending set", 128'(rw_data[3*16 +: 16]), 128'h0004);
      irq_src[2] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      irq_src[2] = 1'b1;
      access(1'b0, 1'b1, 3'd3, 16'h0004);
      check("set beats clear pending", 128'(rw_data[3*16 +: 16]), 128'h0004);
      check("set beats clear irq", 128'(irq), 128'h1);
      irq_src[2] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      access(1'b0, 1'b1, 3'd3, 16'h0004);
      check("pending cleared", 128'(rw_data[3*16 +: 16]), 128'h0000);
      check("irq cleared", 128'(irq), 128'h0);
`else
      // Without the feature, irq_o stays low and register 3 is plain read-write.
      irq_src = 16'hFFFF;
      repeat (6) @(posedge clk);
      #1;
      irq_src = 16'h0000;
      repeat (6) @(posedge clk);
      #1;
      check("irq tied low", 128'(irq), 128'h0);
      access(1'b0, 1'b1, 3'd3, 16'h0004);
      access(1'b1, 1'b0, 3'd3, 16'h0000);
      check("reg3 plain rw", 128'(bus_if.data_o), 128'h0004);
      seen = 1'b0;
`endif

      // Reset in the middle of an access, with cs_i kept high across the release.
      access(1'b0, 1'b1, 3'd1, 16'h1111);
      access(1'b1, 1'b0, 3'd1, 16'h0000);
      check("pre-reset data_o", 128'(bus_if.data_o), 128'h1111);
      bus_if.addr_i   = 3'd0;
      bus_if.read_n_i = 1'b0;
      bus_if.cs_i     = 1'b1;
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("midreset data_o", 128'(bus_if.data_o), 128'h0);
      check("midreset rw_data_o", rw_data, 128'h0);
      check("midreset irq_o", 128'(irq), 128'h0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1 check("refill edge n", 128'(bus_if.data_o), 128'h0);
      @(posedge clk); #1 check("refill edge n+1", 128'(bus_if.data_o), 128'h0);
      @(posedge clk); #1 check("refill edge n+2", 128'(bus_if.data_o), 128'(ID));
      bus_if.cs_i     = 1'b0;
      bus_if.read_n_i = 1'b1;
      repeat (S + 1) @(posedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
